// File: rtl/grid_cursor_ctrl_if.sv
// Display-side drawing handshake for the step-sequencer grid.
//   X, Y          cursor cell pixel origin
//   OLD_X, OLD_Y  pixel origin of the cell to repaint
//   state         grid value of the repainted cell (1 = active)
//   draw_enable   one-cycle draw request to the display stage
//   drawing       display busy flag, driven by the display stage
// master = command stage (grid_cursor_ctrl), slave = display stage.
interface grid_cursor_ctrl_if;
   logic [9:0] X;
   logic [8:0] Y;
   logic [9:0] OLD_X;
   logic [8:0] OLD_Y;
   logic       state;
   logic       draw_enable;
   logic       drawing;

   modport master (
      output X, Y, OLD_X, OLD_Y, state, draw_enable,
      input  drawing
   );

   modport slave (
      input  X, Y, OLD_X, OLD_Y, state, draw_enable,
      output drawing
   );
endinterface

// File: rtl/grid_cursor_ctrl.sv
// Command stage for the step-sequencer grid display.
// Holds the NxN step grid and the cursor, executes move/toggle pulses, presents the
// cursor and repaint coordinates to the display and waits for each draw to finish.
//   CLOCK_50, nReset    clock, asynchronous active-low reset
//   btn_*               one-cycle command pulses (priority toggle > up > down > left > right)
//   disp                drawing handshake (master side)
//   col_sel, col_bits   combinational column read for playback (bit r = row r)
//   busy                high whenever the FSM is not idle
//   cmd_dropped         one-cycle pulse when a command is discarded
module grid_cursor_ctrl #(
   parameter int unsigned X0      = 214,
   parameter int unsigned Y0      = 32,
   parameter int unsigned PITCH   = 33,
   parameter int unsigned N       = 12,
   parameter int unsigned SETTLE  = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                CLOCK_50,
   input  logic                nReset,
   input  logic                btn_up,
   input  logic                btn_down,
   input  logic                btn_left,
   input  logic                btn_right,
   input  logic                btn_toggle,
   grid_cursor_ctrl_if.master  disp,
   input  logic [3:0]          col_sel,
   output logic [N-1:0]        col_bits,
   output logic                busy,
   output logic                cmd_dropped
);

   typedef enum logic [2:0] {StInitWait, StIdle, StIssue, StWaitStart, StWaitDone} fsm_e;
   typedef enum logic [2:0] {CmdNone, CmdToggle, CmdUp, CmdDown, CmdLeft, CmdRight} cmd_e;

   localparam logic [3:0] NLast       = 4'(N - 1);
   localparam logic [9:0] TimeoutLast = 10'(TIMEOUT - 1);
   localparam logic [9:0] SettleLast  = 10'(SETTLE - 1);

   function automatic logic [9:0] px(input logic [3:0] c);
      return 10'(X0 + PITCH * c);
   endfunction

   function automatic logic [8:0] py(input logic [3:0] r);
      return 9'(Y0 + PITCH * r);
   endfunction

   fsm_e                 fsm_q, fsm_d;
   logic [9:0]           cnt_q, cnt_d;
   logic                 pend_valid_q, pend_valid_d;
   cmd_e                 pend_q, pend_d;
   logic                 drop_q, drop_d;
   logic [3:0]           col_q, col_d, row_q, row_d;
   logic [N-1:0][N-1:0]  grid_q, grid_d;  // grid_q[col][row]
   logic [9:0]           x_q, x_d, old_x_q, old_x_d;
   logic [8:0]           y_q, y_d, old_y_q, old_y_d;
   logic                 st_q, st_d;
   cmd_e                 cmd_new, exec;

   always_comb begin
      if (btn_toggle)     cmd_new = CmdToggle;
      else if (btn_up)    cmd_new = CmdUp;
      else if (btn_down)  cmd_new = CmdDown;
      else if (btn_left)  cmd_new = CmdLeft;
      else if (btn_right) cmd_new = CmdRight;
      else                cmd_new = CmdNone;
   end

   always_comb begin
      fsm_d        = fsm_q;
      cnt_d        = cnt_q;
      pend_valid_d = pend_valid_q;
      pend_d       = pend_q;
      drop_d       = 1'b0;
      col_d        = col_q;
      row_d        = row_q;
      grid_d       = grid_q;
      x_d          = x_q;
      y_d          = y_q;
      old_x_d      = old_x_q;
      old_y_d      = old_y_q;
      st_d         = st_q;
      exec         = CmdNone;

      unique case (fsm_q)
         // Power-up wait behaves like a draw wait: rise of drawing, then settle.
         StInitWait, StWaitStart: begin
            if (disp.drawing) begin
               fsm_d = StWaitDone;
               cnt_d = '0;
            end else if (cnt_q == TimeoutLast) begin
               fsm_d = StIdle;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         StIdle: begin
            if (pend_valid_q) begin
               exec = pend_q;
               if (cmd_new != CmdNone) pend_d = cmd_new;
               else                    pend_valid_d = 1'b0;
            end else begin
               exec = cmd_new;
            end
            if (exec != CmdNone) fsm_d = StIssue;
         end
         StIssue: begin
            fsm_d = StWaitStart;
            cnt_d = '0;
         end
         // Consecutive-zero count so the short gap between box and cursor phases is ignored.
         StWaitDone: begin
            if (disp.drawing) begin
               cnt_d = '0;
            end else if (cnt_q == SettleLast) begin
               fsm_d = StIdle;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         default: fsm_d = StIdle;
      endcase

      if (fsm_q != StIdle && cmd_new != CmdNone) begin
         if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_d       = cmd_new;
         end else begin
            drop_d = 1'b1;
         end
      end

      case (exec)
         CmdToggle: begin
            grid_d[col_q][row_q] = ~grid_q[col_q][row_q];
            old_x_d              = x_q;
            old_y_d              = y_q;
            st_d                 = ~grid_q[col_q][row_q];
         end
         CmdUp, CmdDown, CmdLeft, CmdRight: begin
            if (exec == CmdUp)    row_d = (row_q == 4'd0) ? NLast : row_q - 4'd1;
            if (exec == CmdDown)  row_d = (row_q == NLast) ? 4'd0 : row_q + 4'd1;
            if (exec == CmdLeft)  col_d = (col_q == 4'd0) ? NLast : col_q - 4'd1;
            if (exec == CmdRight) col_d = (col_q == NLast) ? 4'd0 : col_q + 4'd1;
            old_x_d = x_q;
            old_y_d = y_q;
            st_d    = grid_q[col_q][row_q];
            x_d     = px(col_d);
            y_d     = py(row_d);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         fsm_q        <= StInitWait;
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_q       <= CmdNone;
         drop_q       <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         grid_q       <= '0;
         x_q          <= px(4'd0);
         y_q          <= py(4'd0);
         old_x_q      <= px(4'd0);
         old_y_q      <= py(4'd0);
         st_q         <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_q       <= pend_d;
         drop_q       <= drop_d;
         col_q        <= col_d;
         row_q        <= row_d;
         grid_q       <= grid_d;
         x_q          <= x_d;
         y_q          <= y_d;
         old_x_q      <= old_x_d;
         old_y_q      <= old_y_d;
         st_q         <= st_d;
      end
   end

   assign disp.X           = x_q;
   assign disp.Y           = y_q;
   assign disp.OLD_X       = old_x_q;
   assign disp.OLD_Y       = old_y_q;
   assign disp.state       = st_q;
   assign disp.draw_enable = (fsm_q == StIssue);
   assign busy             = (fsm_q != StIdle);
   assign cmd_dropped      = drop_q;
   assign col_bits         = (col_sel <= NLast) ? grid_q[col_sel] : '0;

endmodule

// File: doc/grid_cursor_ctrl.md
Name: grid_cursor_ctrl

Overview:
- Upstream command stage for the step-sequencer grid display.
- Holds the 12x12 step grid (1 bit per cell) and the cursor position. It accepts move and toggle pulses from the debounced input stage.
- For each accepted command it presents pixel coordinates to the display stage (X/Y for the cursor, OLD_X/OLD_Y plus state for the repainted cell) and pulses draw_enable. It then waits for the drawing handshake to complete before issuing the next command.
- Also exposes a combinational column read port for the playback engine.

Parameters:
- X0, 214, pixel x of cell column 0.
- Y0, 32, pixel y of cell row 0.
- PITCH, 33, pixel distance between adjacent cell origins.
- N, 12, cells per row and per column.
- SETTLE, 4, consecutive drawing==0 cycles that mark a draw as complete.
- TIMEOUT, 1023, max cycles to wait for drawing to rise before giving up.

Ports:
- CLOCK_50  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- btn_up  in  1  one-cycle pulse: move cursor up (row-1)
- btn_down  in  1  one-cycle pulse: move cursor down (row+1)
- btn_left  in  1  one-cycle pulse: move cursor left (col-1)
- btn_right  in  1  one-cycle pulse: move cursor right (col+1)
- btn_toggle  in  1  one-cycle pulse: invert the grid bit under the cursor
- drawing  in  1  display busy flag
- col_sel  in  4  column index for the playback read
- col_bits  out  12  grid bits of column col_sel, bit r = row r; combinational
- X  out  10  cursor cell pixel x
- Y  out  9  cursor cell pixel y
- OLD_X  out  10  pixel x of the cell to repaint
- OLD_Y  out  9  pixel y of the cell to repaint
- state  out  1  grid value of the repainted cell (1 = active/blue)
- draw_enable  out  1  one-cycle draw request
- busy  out  1  high whenever FSM is not IDLE
- cmd_dropped  out  1  one-cycle pulse when a command is discarded

Behaviour:
- Reset (asynchronous):
  - grid all 0; cursor col=0, row=0.
  - X=OLD_X=214, Y=OLD_Y=32, state=0.
  - draw_enable=0, cmd_dropped=0, busy=1.
  - FSM enters INIT_WAIT.
  - Reset mid-draw discards any pending command.
- Coordinates, all registered:
  - X = X0 + PITCH*col, Y = Y0 + PITCH*row.
  - Maximum values are 577 and 395, which fit 10 and 9 bits.
  - Computed from the post-command cursor and stable from the draw_enable cycle until return to IDLE; the display samples them live.
- Command decode: one command per cycle. Priority is toggle > up > down > left > right; lower-priority simultaneous pulses are ignored and do not count as drops.
- Moves wrap: col 0 left -> 11, col 11 right -> 0; same for rows.
- Move command:
  - OLD_X/OLD_Y = old cursor cell, state = grid[old cell].
  - Cursor and X/Y take the new cell.
  - Grid is unchanged.
- Toggle command:
  - grid[cursor] inverts.
  - OLD_X/OLD_Y = X/Y = cursor cell, state = new bit value.
- FSM:
  - INIT_WAIT: waits for the display's power-up grid draw. Wait for drawing==1, then SETTLE consecutive zeros -> IDLE. If drawing never rises within TIMEOUT cycles -> IDLE.
  - IDLE: if the pending slot is valid, execute it. Otherwise, if a new command is present, execute it. Execution updates registers at the clock edge and moves to ISSUE. If the pending slot and a new command exist together, the new command replaces the slot.
  - ISSUE: draw_enable=1 for exactly this one cycle -> WAIT_START.
  - WAIT_START: drawing==1 -> WAIT_DONE. TIMEOUT cycles elapse -> IDLE.
  - WAIT_DONE: count consecutive drawing==0 cycles; any drawing==1 resets the count. On reaching SETTLE -> IDLE. This makes the 1-cycle low gap between box and cursor phases not end the wait.
- Latency: a command sampled in IDLE at cycle n gives updated outputs and draw_enable=1 at cycle n+1.
- Pending slot (one deep):
  - A command arriving while busy=1 (including INIT_WAIT) is stored if the slot is empty.
  - If the slot is full, the new command is discarded and cmd_dropped pulses in the following cycle.
- col_bits reads the current grid. A toggle is visible the cycle after its execution edge.
- col_sel >= 12 -> col_bits = 0.

Test Plan:
- Reset released, drawing pulses high for 50 cycles then low -> X=214, Y=32, busy falls 4 cycles after drawing falls, draw_enable never asserted.
- From IDLE at (0,0), btn_right -> next cycle draw_enable=1 for exactly 1 cycle, X=247, Y=32, OLD_X=214, OLD_Y=32, state=0.
- btn_left at col 0 -> X=577. Then btn_up at row 0 -> Y=395, OLD_Y=32.
- btn_toggle at (3,5), i.e. col 3, row 5 -> state=1, OLD_X=X=313, OLD_Y=Y=197. With col_sel=3, col_bits=12'h020. Second toggle -> state=0, col_bits=0.
- During WAIT_DONE, drawing goes 1,0,1,0,0,0,0 -> return to IDLE only after the final four zeros. btn_right and btn_down issued while busy -> right executes after IDLE, down is dropped with a cmd_dropped pulse.
- After draw_enable, drawing held 0 -> return to IDLE after 1023 cycles. Next command issues normally.
